// File: rtl/mem_block_copier_if.sv
// Bus bundle for mem_block_copier: control handshake, memory port 1 (read) and port 2 (write).
// Fill ports are present only when MEMCOPY_FILL_EN is defined.
interface mem_block_copier_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              start;
   logic [ADDR_W-1:0] src_addr;
   logic [ADDR_W-1:0] dst_addr;
   logic [ADDR_W-1:0] len;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] mem_a1;
   logic              mem_read1;
   logic [DATA_W-1:0] mem_r1;
   logic [ADDR_W-1:0] mem_a2;
   logic [DATA_W-1:0] mem_w2;
   logic              mem_write2;
   logic [1:0]        state_dbg;
`ifdef MEMCOPY_FILL_EN
   logic              fill;
   logic [DATA_W-1:0] fill_value;

   modport master (
      input  start, src_addr, dst_addr, len, mem_r1, fill, fill_value,
      output busy, done, mem_a1, mem_read1, mem_a2, mem_w2, mem_write2, state_dbg
   );
   modport slave (
      output start, src_addr, dst_addr, len, mem_r1, fill, fill_value,
      input  busy, done, mem_a1, mem_read1, mem_a2, mem_w2, mem_write2, state_dbg
   );
`else
   modport master (
      input  start, src_addr, dst_addr, len, mem_r1,
      output busy, done, mem_a1, mem_read1, mem_a2, mem_w2, mem_write2, state_dbg
   );
   modport slave (
      output start, src_addr, dst_addr, len, mem_r1,
      input  busy, done, mem_a1, mem_read1, mem_a2, mem_w2, mem_write2, state_dbg
   );
`endif
endinterface

// File: rtl/mem_block_copier.sv
// Block copier (memmove) between port 1 (read) and port 2 (write) of a dual-port memory.
// Optional MEMCOPY_FILL_EN adds a fill mode that writes a constant to the destination.
module mem_block_copier #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   mem_block_copier_if.master   bus
);

   // Handshake: start is a one-cycle request honoured only in IDLE; busy covers the
   // copy and done pulses for one cycle after the last write, after which start is
   // accepted again. Reads are answered one cycle after the strobe.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t            state, state_nx;
   logic              busy_q, busy_d, done_q, done_d;
   logic              rd_q, rd_d, wr_q, wr_d;
   logic              desc_q, desc_d, fill_q, fill_d;
   logic [ADDR_W-1:0] a1_q, a1_d, a2_q, a2_d;
   logic [ADDR_W-1:0] wnext_q, wnext_d, rem_q, rem_d;
   logic [ADDR_W-1:0] step, last_off;
   logic              fill_in, go_desc;

`ifdef MEMCOPY_FILL_EN
   logic [DATA_W-1:0] fval_q, fval_d;
   assign fill_in    = bus.fill;
   assign bus.mem_w2 = fill_q ? fval_q : bus.mem_r1;
`else
   assign fill_in    = 1'b0;
   assign bus.mem_w2 = bus.mem_r1;
`endif

   assign step     = desc_q ? {ADDR_W{1'b1}} : ADDR_W'(1);
   assign last_off = bus.len - ADDR_W'(1);
   // Copying upwards into an overlapping region must start from the top word.
   assign go_desc  = (bus.dst_addr > bus.src_addr) && !fill_in;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (bus.start) state_nx = (bus.len == '0) ? S_DRAIN : S_RUN;
         S_RUN:   if (rem_q == '0) state_nx = fill_q ? S_DONE : S_DRAIN;
         S_DRAIN: state_nx = S_DONE;
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      busy_d  = busy_q;
      done_d  = 1'b0;
      rd_d    = rd_q;
      wr_d    = wr_q;
      a1_d    = a1_q;
      a2_d    = a2_q;
      wnext_d = wnext_q;
      rem_d   = rem_q;
      desc_d  = desc_q;
      fill_d  = fill_q;
`ifdef MEMCOPY_FILL_EN
      fval_d  = fval_q;
`endif
      case (state)
         S_IDLE: begin
            if (bus.start) begin
               busy_d = 1'b1;
               desc_d = go_desc;
               fill_d = fill_in;
               rem_d  = last_off;
`ifdef MEMCOPY_FILL_EN
               fval_d = bus.fill_value;
`endif
               // A zero-length request passes through DRAIN with no strobe raised.
               if (bus.len != '0) begin
                  if (fill_in) begin
                     wr_d    = 1'b1;
                     a2_d    = bus.dst_addr;
                     wnext_d = bus.dst_addr + ADDR_W'(1);
                  end else begin
                     rd_d    = 1'b1;
                     a1_d    = go_desc ? bus.src_addr + last_off : bus.src_addr;
                     wnext_d = go_desc ? bus.dst_addr + last_off : bus.dst_addr;
                  end
               end
            end
         end
         S_RUN: begin
            if (fill_q) begin
               if (rem_q == '0) begin
                  wr_d   = 1'b0;
                  busy_d = 1'b0;
                  done_d = 1'b1;
               end else begin
                  a2_d    = wnext_q;
                  wnext_d = wnext_q + ADDR_W'(1);
                  rem_d   = rem_q - ADDR_W'(1);
               end
            end else begin
               // Write of the word read last cycle, alongside the next read.
               wr_d    = 1'b1;
               a2_d    = wnext_q;
               wnext_d = wnext_q + step;
               if (rem_q == '0) begin
                  rd_d = 1'b0;
               end else begin
                  a1_d  = a1_q + step;
                  rem_d = rem_q - ADDR_W'(1);
               end
            end
         end
         S_DRAIN: begin
            wr_d   = 1'b0;
            busy_d = 1'b0;
            done_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         a1_q    <= '0;
         a2_q    <= '0;
         wnext_q <= '0;
         rem_q   <= '0;
         desc_q  <= 1'b0;
         fill_q  <= 1'b0;
`ifdef MEMCOPY_FILL_EN
         fval_q  <= '0;
`endif
      end else begin
         busy_q  <= busy_d;
         done_q  <= done_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         a1_q    <= a1_d;
         a2_q    <= a2_d;
         wnext_q <= wnext_d;
         rem_q   <= rem_d;
         desc_q  <= desc_d;
         fill_q  <= fill_d;
`ifdef MEMCOPY_FILL_EN
         fval_q  <= fval_d;
`endif
      end
   end

   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.mem_a1     = a1_q;
   assign bus.mem_read1  = rd_q;
   assign bus.mem_a2     = a2_q;
   assign bus.mem_write2 = wr_q;
   assign bus.state_dbg  = state;

endmodule

// File: tb/tb_mem_block_copier.sv
// Testbench for mem_block_copier: memory model, memmove reference, write scoreboard.
// Build with MEMCOPY_FILL_EN defined to also exercise the fill mode.
module tb_mem_block_copier;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;
   bit   seen_read;

   logic [31:0] exp_q[$];
   logic [15:0] mem [0:65535];
   logic [15:0] rdata;

   mem_block_copier_if #(.ADDR_W(16), .DATA_W(16)) bus ();

   mem_block_copier #(.ADDR_W(16), .DATA_W(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Dual-port memory: registered read returns the pre-write word on a collision.
   assign bus.mem_r1 = rdata;
   always @(posedge clk) begin
      if (bus.mem_read1) rdata <= mem[bus.mem_a1];
      if (bus.mem_write2) mem[bus.mem_a2] = bus.mem_w2;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      logic [31:0] e;
      if (rst_n) begin
         if (bus.mem_read1) seen_read = 1'b1;
         if (bus.mem_write2) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: got addr %h data %h, none expected",
                        bus.mem_a2, bus.mem_w2);
            end else begin
               e = exp_q.pop_front();
               check("write", {bus.mem_a2, bus.mem_w2}, e);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic set_fill(input bit f, input logic [15:0] v);
`ifdef MEMCOPY_FILL_EN
      bus.fill       = f;
      bus.fill_value = v;
`else
      if (f || (v != v)) $display("fill request ignored in copy-only build");
`endif
   endtask

   task automatic run_copy(input logic [15:0] src, input logic [15:0] dst,
                           input logic [15:0] len, input bit fill, input logic [15:0] fval);
      logic [15:0] orig[$];
      logic [15:0] a, idx;
      bit          desc;
      int          busy_cyc, done_cyc, done_hi, bad, exp_done, exp_busy;
      orig.delete();
      for (int i = 0; i < int'(len); i++) begin
         a = src + 16'(i);
         orig.push_back(mem[a]);
      end
      // Reference: memmove of the snapshot, in the order implied by direction.
      desc = (dst > src) && !fill;
      for (int k = 0; k < int'(len); k++) begin
         idx = desc ? (len - 16'd1 - 16'(k)) : 16'(k);
         exp_q.push_back({dst + idx, fill ? fval : orig[idx]});
      end
      exp_done = (fill && len != 0) ? int'(len) + 1 : int'(len) + 2;
      exp_busy = exp_done - 1;
      seen_read = 1'b0;
      busy_cyc = 0; done_cyc = 0; done_hi = 0;

      @(negedge clk);
      bus.start    = 1'b1;
      bus.src_addr = src;
      bus.dst_addr = dst;
      bus.len      = len;
      set_fill(fill, fval);
      @(posedge clk);
      #1 bus.start = 1'b0;
      for (int c = 1; c <= int'(len) + 20; c++) begin
         @(negedge clk);
         if (bus.busy) busy_cyc++;
         if (bus.done) begin
            if (done_cyc == 0) done_cyc = c;
            done_hi++;
         end
         if (c == 1) begin
            bus.start    = 1'b1;
            bus.src_addr = 16'($urandom);
            bus.dst_addr = 16'($urandom);
            bus.len      = 16'd5;
            set_fill(1'b0, 16'h0);
         end
         if (c == 2) bus.start = 1'b0;
         if (done_cyc != 0 && c == done_cyc + 2) break;
      end
      check("done_cycle", 32'(done_cyc), 32'(exp_done));
      check("busy_cycles", 32'(busy_cyc), 32'(exp_busy));
      check("done_width", 32'(done_hi), 32'd1);
      check("leftover_writes", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      bad = 0;
      for (int i = 0; i < int'(len); i++) begin
         a = dst + 16'(i);
         if (mem[a] !== (fill ? fval : orig[i])) bad++;
      end
      check("final_mem", 32'(bad), 32'd0);
      if (fill || len == 0) check("no_read", 32'(seen_read), 32'd0);
   endtask

   task automatic load(input logic [15:0] base, input int n, input bit rnd, input logic [15:0] v0);
      logic [15:0] a;
      for (int i = 0; i < n; i++) begin
         a = base + 16'(i);
         mem[a] = rnd ? 16'($urandom) : v0 + 16'(i);
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [15:0] src, dst, len, a;
      int bad;
      errors = 0; checks = 0; seen_read = 1'b0;
      rdata = '0;
      bus.start = 1'b0; bus.src_addr = '0; bus.dst_addr = '0; bus.len = '0;
      set_fill(1'b0, 16'h0);
      for (int i = 0; i < 65536; i++) mem[i] = 16'h0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_read1", 32'(bus.mem_read1), 32'd0);
      check("rst_write2", 32'(bus.mem_write2), 32'd0);
      check("rst_a1", 32'(bus.mem_a1), 32'd0);
      check("rst_a2", 32'(bus.mem_a2), 32'd0);
      check("rst_state", 32'(bus.state_dbg), 32'd0);

      // Basic copy
      mem[16'h10] = 16'hA0A0; mem[16'h11] = 16'hB1B1; mem[16'h12] = 16'hC2C2; mem[16'h13] = 16'hD3D3;
      run_copy(16'h0010, 16'h0040, 16'd4, 1'b0, 16'h0);
      check("src_kept", {mem[16'h10], mem[16'h13]}, 32'hA0A0_D3D3);
      check("dst_word2", 32'(mem[16'h42]), 32'h0000_C2C2);

      // Forward overlap -> descending
      load(16'h0020, 8, 1'b0, 16'd0);
      run_copy(16'h0020, 16'h0022, 16'd6, 1'b0, 16'h0);
      bad = 0;
      for (int i = 0; i < 6; i++) if (mem[16'h22 + 16'(i)] !== 16'(i)) bad++;
      check("fwd_overlap", 32'(bad), 32'd0);

      // Backward overlap -> ascending
      load(16'h0020, 2, 1'b0, 16'h0077);
      load(16'h0022, 6, 1'b0, 16'd0);
      run_copy(16'h0022, 16'h0020, 16'd6, 1'b0, 16'h0);
      bad = 0;
      for (int i = 0; i < 6; i++) if (mem[16'h20 + 16'(i)] !== 16'(i)) bad++;
      check("bwd_overlap", 32'(bad), 32'd0);

      // Zero length, with a start poked while busy
      run_copy(16'h0100, 16'h0200, 16'd0, 1'b0, 16'h0);
      check("len0_idle", 32'(bus.state_dbg), 32'd0);

      // Randomized copies, non-wrapping
      for (int t = 0; t < 16; t++) begin
         len = 16'($urandom_range(1, 12));
         src = 16'($urandom_range(16'h0100, 16'hE000));
         case ($urandom_range(0, 2))
            0:       dst = src + 16'($urandom_range(1, int'(len)));
            1:       dst = src - 16'($urandom_range(1, int'(len)));
            default: dst = 16'($urandom_range(16'h0100, 16'hE000));
         endcase
         load(src, int'(len), 1'b1, 16'h0);
         run_copy(src, dst, len, 1'b0, 16'h0);
      end

`ifdef MEMCOPY_FILL_EN
      load(16'hFFFE, 4, 1'b0, 16'h1111);
      run_copy(16'h0500, 16'hFFFE, 16'd4, 1'b1, 16'hBEEF);
      check("fill_wrap", {mem[16'hFFFF], mem[16'h0001]}, 32'hBEEF_BEEF);
      load(16'h0600, 5, 1'b1, 16'h0);
      run_copy(16'h0600, 16'h0700, 16'd5, 1'b0, 16'h0);
`endif

      // Reset asserted while the third write is on the bus
      load(16'h0300, 8, 1'b1, 16'h0);
      load(16'h0200, 8, 1'b0, 16'hDEA0);
      for (int k = 0; k < 2; k++) exp_q.push_back({16'h0200 + 16'(k), mem[16'h0300 + 16'(k)]});
      @(negedge clk);
      bus.start = 1'b1; bus.src_addr = 16'h0300; bus.dst_addr = 16'h0200; bus.len = 16'd8;
      set_fill(1'b0, 16'h0);
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("rstmid_read1", 32'(bus.mem_read1), 32'd0);
      check("rstmid_write2", 32'(bus.mem_write2), 32'd0);
      check("rstmid_busy", 32'(bus.busy), 32'd0);
      check("rstmid_done", 32'(bus.done), 32'd0);
      repeat (2) @(negedge clk);
      bad = 0;
      for (int i = 0; i < 8; i++) begin
         a = 16'h0200 + 16'(i);
         if (mem[a] !== 16'hDEA0 + 16'(i)) bad++;
      end
      check("rstmid_written", 32'(bad), 32'd2);
      check("rstmid_queue", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
